// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage. It owns the PC register, issues instruction-memory
//   read requests and delivers a registered IF/ID payload to decode. It
//   tolerates variable memory latency, decode back-pressure (stall), redirects
//   (flush) and misaligned PCs. The PC is never incremented here; it only ever
//   loads RESET_PC or pc_next.
//
// Ports
//   clk          in   clock, all state updates on the rising edge
//   rst_n        in   asynchronous active-low reset
//   pc_next      in   next PC from the PC selection logic (sequential/jump/branch)
//   stall        in   decode cannot accept a new instruction
//   flush        in   one-cycle redirect strobe, pc_next holds the target
//   pc           out  current PC, fed back to the PC selection logic
//   imem_req     out  instruction read request
//   imem_addr    out  read address, stable while a request is outstanding
//   imem_ack     in   imem_rdata valid this cycle, completes one request
//   imem_rdata   in   returned instruction word
//   if_valid     out  IF/ID payload valid
//   if_pc        out  IF/ID PC
//   if_instr     out  IF/ID instruction
//   if_adel      out  IF/ID misaligned-fetch flag
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter int unsigned          ADDR_BITS = 32,
   parameter logic [ADDR_BITS-1:0] RESET_PC  = ADDR_BITS'(32'h0000_3000)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [ADDR_BITS-1:0] pc_next,
   input  logic                 stall,
   input  logic                 flush,
   output logic [ADDR_BITS-1:0] pc,
   output logic                 imem_req,
   output logic [ADDR_BITS-1:0] imem_addr,
   input  logic                 imem_ack,
   input  logic [31:0]          imem_rdata,
   output logic                 if_valid,
   output logic [ADDR_BITS-1:0] if_pc,
   output logic [31:0]          if_instr,
   output logic                 if_adel
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2,
      DROP = 2'd3
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [ADDR_BITS-1:0] pc_nxt;
   logic [ADDR_BITS-1:0] drop_addr;
   logic [ADDR_BITS-1:0] drop_addr_nxt;
   logic [31:0]          hold_buf;
   logic [31:0]          hold_buf_nxt;
   logic                 imem_req_nxt;
   logic [ADDR_BITS-1:0] imem_addr_nxt;
   logic                 if_valid_nxt;
   logic [ADDR_BITS-1:0] if_pc_nxt;
   logic [31:0]          if_instr_nxt;
   logic                 if_adel_nxt;
   logic                 pc_misaligned;

   assign pc_misaligned = (pc[1:0] != 2'b00);

   // Next-state, next-PC and next IF/ID payload; flush dominates everything.
   always_comb begin
      state_nxt     = state;
      pc_nxt        = pc;
      drop_addr_nxt = drop_addr;
      hold_buf_nxt  = hold_buf;
      if_valid_nxt  = if_valid;
      if_pc_nxt     = if_pc;
      if_instr_nxt  = if_instr;
      if_adel_nxt   = if_adel;

      if (flush) begin
         pc_nxt       = pc_next;
         if_valid_nxt = 1'b0;
         case (state)
            BOOT: state_nxt = REQ;
            REQ: begin
               // A request is only in flight when the PC is aligned and the
               // memory has not answered yet; remember its address so the
               // answer can be drained in DROP.
               if (imem_ack || pc_misaligned) begin
                  state_nxt = REQ;
               end else begin
                  state_nxt     = DROP;
                  drop_addr_nxt = pc;
               end
            end
            HOLD: begin
               state_nxt    = REQ;
               hold_buf_nxt = 32'h0000_0000;
            end
            DROP:    state_nxt = DROP;
            default: state_nxt = BOOT;
         endcase
      end else begin
         case (state)
            BOOT: begin
               state_nxt = REQ;
               if (!stall) begin
                  if_valid_nxt = 1'b0;
               end else begin
                  if_valid_nxt = if_valid;
               end
            end
            REQ: begin
               if (pc_misaligned) begin
                  // No request is issued; report the fault and park the PC
                  // until decode redirects us.
                  if (!stall) begin
                     if_valid_nxt = 1'b1;
                     if_pc_nxt    = pc;
                     if_instr_nxt = 32'h0000_0000;
                     if_adel_nxt  = 1'b1;
                  end else begin
                     if_valid_nxt = if_valid;
                  end
               end else if (imem_ack) begin
                  if (stall) begin
                     hold_buf_nxt = imem_rdata;
                     state_nxt    = HOLD;
                  end else begin
                     if_valid_nxt = 1'b1;
                     if_pc_nxt    = pc;
                     if_instr_nxt = imem_rdata;
                     if_adel_nxt  = 1'b0;
                     pc_nxt       = pc_next;
                  end
               end else if (!stall) begin
                  if_valid_nxt = 1'b0;
               end else begin
                  if_valid_nxt = if_valid;
               end
            end
            HOLD: begin
               // pc still names the buffered instruction while holding.
               if (!stall) begin
                  if_valid_nxt = 1'b1;
                  if_pc_nxt    = pc;
                  if_instr_nxt = hold_buf;
                  if_adel_nxt  = 1'b0;
                  pc_nxt       = pc_next;
                  state_nxt    = REQ;
               end else begin
                  state_nxt = HOLD;
               end
            end
            DROP: begin
               if (imem_ack) begin
                  state_nxt = REQ;
               end else begin
                  state_nxt = DROP;
               end
               if (!stall) begin
                  if_valid_nxt = 1'b0;
               end else begin
                  if_valid_nxt = if_valid;
               end
            end
            default: state_nxt = BOOT;
         endcase
      end

      // Memory-side outputs are registered, so derive them from next state.
      imem_req_nxt  = (state_nxt == DROP) ||
                      ((state_nxt == REQ) && (pc_nxt[1:0] == 2'b00));
      imem_addr_nxt = (state_nxt == DROP) ? drop_addr_nxt : pc_nxt;
   end

   // State, PC, buffers and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= BOOT;
         pc        <= RESET_PC;
         drop_addr <= RESET_PC;
         hold_buf  <= 32'h0000_0000;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
         if_valid  <= 1'b0;
         if_pc     <= '0;
         if_instr  <= 32'h0000_0000;
         if_adel   <= 1'b0;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         drop_addr <= drop_addr_nxt;
         hold_buf  <= hold_buf_nxt;
         imem_req  <= imem_req_nxt;
         imem_addr <= imem_addr_nxt;
         if_valid  <= if_valid_nxt;
         if_pc     <= if_pc_nxt;
         if_instr  <= if_instr_nxt;
         if_adel   <= if_adel_nxt;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage. A transaction-level reference model
//   (flags for "booting", "buffered instruction", "draining a cancelled read")
//   predicts every output each cycle. Directed scenarios cover the reset,
//   back-to-back, stall, flush-with-latency, flush+stall, misaligned and
//   reset-during-drain cases, then a randomized run with a variable-latency
//   memory, random stall/flush/targets and occasional resets.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_3000;

   logic        clk;
   logic        rst_n;
   logic [31:0] pc_next;
   logic        stall;
   logic        flush;
   logic [31:0] pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_adel;

   fetch_stage #(.ADDR_BITS(32), .RESET_PC(RST_PC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pc_next    (pc_next),
      .stall      (stall),
      .flush      (flush),
      .pc         (pc),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .if_valid   (if_valid),
      .if_pc      (if_pc),
      .if_instr   (if_instr),
      .if_adel    (if_adel)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // reference model state
   bit          m_booting;
   bit          m_buf_full;
   logic [31:0] m_buf;
   bit          m_dropping;
   logic [31:0] m_drop_addr;
   logic [31:0] m_pc;
   logic        m_valid;
   logic [31:0] m_ifpc;
   logic [31:0] m_instr;
   logic        m_adel;
   int          mem_cnt;
   logic [31:0] last_rdata;
   logic [31:0] saved;

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %0h exp %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic model_req();
      return !m_booting && !m_buf_full && (m_dropping || (m_pc[1:0] == 2'b00));
   endfunction

   function automatic logic [31:0] model_addr();
      return m_dropping ? m_drop_addr : m_pc;
   endfunction

   task automatic model_reset();
      m_booting  = 1'b1;
      m_buf_full = 1'b0;
      m_buf      = 32'h0;
      m_dropping = 1'b0;
      m_drop_addr = RST_PC;
      m_pc       = RST_PC;
      m_valid    = 1'b0;
      m_ifpc     = 32'h0;
      m_instr    = 32'h0;
      m_adel     = 1'b0;
      mem_cnt    = 0;
   endtask

   task automatic deliver(input logic [31:0] a, input logic [31:0] d, input logic f);
      m_valid = 1'b1;
      m_ifpc  = a;
      m_instr = d;
      m_adel  = f;
   endtask

   // Apply this cycle's inputs to the model (what the DUT will do at the edge).
   task automatic model_step();
      if (m_booting) begin
         m_booting = 1'b0;
         if (flush) m_pc = pc_next;
         if (flush || !stall) m_valid = 1'b0;
      end else if (flush) begin
         m_valid = 1'b0;
         if (m_buf_full) begin
            m_buf_full = 1'b0;
         end else if (!m_dropping && !imem_ack && (m_pc[1:0] == 2'b00)) begin
            m_dropping  = 1'b1;
            m_drop_addr = m_pc;
         end
         m_pc = pc_next;
      end else if (m_buf_full) begin
         if (!stall) begin
            deliver(m_pc, m_buf, 1'b0);
            m_pc       = pc_next;
            m_buf_full = 1'b0;
         end
      end else if (m_dropping) begin
         if (imem_ack) m_dropping = 1'b0;
         if (!stall) m_valid = 1'b0;
      end else if (m_pc[1:0] != 2'b00) begin
         if (!stall) deliver(m_pc, 32'h0, 1'b1);
      end else if (imem_ack) begin
         if (stall) begin
            m_buf_full = 1'b1;
            m_buf      = imem_rdata;
         end else begin
            deliver(m_pc, imem_rdata, 1'b0);
            m_pc = pc_next;
         end
      end else if (!stall) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic compare_outputs();
      check_value("pc",        pc,        m_pc);
      check_value("imem_req",  imem_req,  model_req());
      check_value("imem_addr", imem_addr, model_addr());
      check_value("if_valid",  if_valid,  m_valid);
      check_value("if_pc",     if_pc,     m_ifpc);
      check_value("if_instr",  if_instr,  m_instr);
      check_value("if_adel",   if_adel,   m_adel);
   endtask

   task automatic advance();
      model_step();
      @(negedge clk);
      cyc++;
   endtask

   // Called at a negedge; pulses reset mid-cycle and checks the async values.
   task automatic do_reset();
      stall    = 1'b0;
      flush    = 1'b0;
      imem_ack = 1'b0;
      pc_next  = RST_PC;
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      compare_outputs();
      check_value("rst_req",  imem_req,  1'b0);
      check_value("rst_addr", imem_addr, RST_PC);
      @(posedge clk);
      #1 compare_outputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drive(input logic st, input logic fl, input logic [31:0] pn, input logic ak);
      compare_outputs();
      stall      = st;
      flush      = fl;
      pc_next    = pn;
      imem_ack   = ak;
      imem_rdata = $urandom;
      last_rdata = imem_rdata;
      advance();
   endtask

   task automatic random_cycle();
      logic [31:0] tgt;
      compare_outputs();
      stall      = ($urandom_range(0, 3) == 0);
      flush      = ($urandom_range(0, 11) == 0);
      imem_rdata = $urandom;
      if (model_req()) begin
         if (mem_cnt == 0) begin
            imem_ack = 1'b1;
            mem_cnt  = int'($urandom_range(0, 3));
         end else begin
            imem_ack = 1'b0;
            mem_cnt--;
         end
      end else begin
         imem_ack = 1'b0;
      end
      if (flush) begin
         tgt = RST_PC + (32'($urandom_range(0, 1023)) << 2);
         if ($urandom_range(0, 7) == 0) tgt = tgt + 32'd2;
         pc_next = tgt;
      end else begin
         pc_next = m_pc + (($urandom_range(0, 39) == 0) ? 32'd2 : 32'd4);
      end
      advance();
   endtask

   initial begin
      rst_n      = 1'b1;
      stall      = 1'b0;
      flush      = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      pc_next    = RST_PC;
      model_reset();

      // Back-to-back fetch with zero-wait memory.
      do_reset();
      drive(1'b0, 1'b0, m_pc + 32'd4, model_req());
      check_value("first_req",  imem_req,  1'b1);
      check_value("first_addr", imem_addr, 32'h0000_3000);
      drive(1'b0, 1'b0, m_pc + 32'd4, model_req());
      check_value("seq0_pc", if_pc, 32'h0000_3000);
      drive(1'b0, 1'b0, m_pc + 32'd4, model_req());
      check_value("seq1_pc", if_pc, 32'h0000_3004);
      drive(1'b0, 1'b0, m_pc + 32'd4, model_req());
      check_value("seq2_pc", if_pc, 32'h0000_3008);
      check_value("seq2_v",  if_valid, 1'b1);

      // Ack for 0x3004 arrives under a 3-cycle stall.
      do_reset();
      drive(1'b0, 1'b0, m_pc + 32'd4, 1'b0);
      drive(1'b0, 1'b0, m_pc + 32'd4, 1'b1);
      saved = last_rdata;
      drive(1'b1, 1'b0, m_pc + 32'd4, 1'b1);
      check_value("hold_req0", imem_req, 1'b0);
      drive(1'b1, 1'b0, m_pc + 32'd4, 1'b0);
      check_value("hold_req1", imem_req, 1'b0);
      check_value("hold_instr", if_instr, saved);
      saved = m_buf;
      drive(1'b1, 1'b0, m_pc + 32'd4, 1'b0);
      check_value("hold_req2", imem_req, 1'b0);
      drive(1'b0, 1'b0, m_pc + 32'd4, 1'b0);
      check_value("unhold_pc",    if_pc,    32'h0000_3004);
      check_value("unhold_instr", if_instr, saved);
      check_value("unhold_v",     if_valid, 1'b1);

      // Flush during a 3-cycle-latency read of 0x3008.
      do_reset();
      drive(1'b0, 1'b0, m_pc + 32'd4, 1'b0);
      drive(1'b0, 1'b0, m_pc + 32'd4, 1'b1);
      drive(1'b0, 1'b0, m_pc + 32'd4, 1'b1);
      drive(1'b0, 1'b0, m_pc + 32'd4, 1'b0);
      drive(1'b0, 1'b1, 32'h0000_4000, 1'b0);
      check_value("drop_addr0", imem_addr, 32'h0000_3008);
      check_value("drop_pc",    pc,        32'h0000_4000);
      drive(1'b0, 1'b0, m_pc + 32'd4, 1'b0);
      check_value("drop_addr1", imem_addr, 32'h0000_3008);
      drive(1'b0, 1'b0, m_pc + 32'd4, 1'b1);
      check_value("redir_addr", imem_addr, 32'h0000_4000);
      check_value("redir_req",  imem_req,  1'b1);
      check_value("drop_nov",   if_valid,  1'b0);

      // Flush and stall together while holding.
      do_reset();
      drive(1'b0, 1'b0, m_pc + 32'd4, 1'b0);
      drive(1'b1, 1'b0, m_pc + 32'd4, 1'b1);
      drive(1'b1, 1'b1, 32'h0000_5000, 1'b0);
      check_value("fs_valid", if_valid,  1'b0);
      check_value("fs_pc",    pc,        32'h0000_5000);
      check_value("fs_addr",  imem_addr, 32'h0000_5000);

      // Misaligned PC, then redirect.
      do_reset();
      drive(1'b0, 1'b0, m_pc + 32'd4, 1'b0);
      drive(1'b0, 1'b0, 32'h0000_3002, 1'b1);
      check_value("mis_req", imem_req, 1'b0);
      drive(1'b0, 1'b0, m_pc + 32'd4, 1'b0);
      check_value("mis_v",     if_valid, 1'b1);
      check_value("mis_pc",    if_pc,    32'h0000_3002);
      check_value("mis_instr", if_instr, 32'h0000_0000);
      check_value("mis_adel",  if_adel,  1'b1);
      drive(1'b0, 1'b1, 32'h0000_3010, 1'b0);
      check_value("mis_redir_req",  imem_req,  1'b1);
      check_value("mis_redir_addr", imem_addr, 32'h0000_3010);

      // Reset during DROP, then a late ack while booting.
      do_reset();
      drive(1'b0, 1'b0, m_pc + 32'd4, 1'b0);
      drive(1'b0, 1'b0, m_pc + 32'd4, 1'b0);
      drive(1'b0, 1'b1, 32'h0000_4000, 1'b0);
      do_reset();
      drive(1'b0, 1'b0, m_pc + 32'd4, 1'b1);
      check_value("late_v",    if_valid,  1'b0);
      check_value("late_addr", imem_addr, 32'h0000_3000);
      drive(1'b0, 1'b0, m_pc + 32'd4, 1'b1);
      check_value("restart_pc", if_pc, 32'h0000_3000);

      // Randomized run.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end
         random_cycle();
      end
      compare_outputs();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
